fifo_byte_packer: RTL and testbench
===================================

// Module: fifo_byte_packer
// PURPOSE
//  Upstream feeder for the sync FIFO: accepts a byte stream (vld/rdy), packs LANES bytes
//  little-endian into one DW-bit word, issues one registered push per word into the FIFO.
//  Back-pressure from FIFO alFull; FIFO HEADROOM (6) absorbs the push->wen->cnt->alFull loop.
// PARAMETERS
//  BW     8      input byte width
//  LANES  3      bytes per FIFO word; DW = BW*LANES (localparam, 24 by default)
//  PAD    8'h00  fill value for unwritten lanes (BW bits)
// PORTS
//  clk          in   1    clock, all flops rising edge
//  rst          in   1    async reset, active-high
//  in_vld       in   1    input byte valid
//  in_data      in   BW   input byte
//  in_last      in   1    last byte of packet (used only with PACKER_PAD_EN)
//  in_rdy       out  1    packer accepts byte this cycle
//  fifo_alFull  in   1    FIFO almost-full
//  fifo_full    in   1    FIFO full (overflow detection only)
//  push         out  1    FIFO push, registered, 1-cycle pulse per word
//  push_data    out  DW   FIFO data_in, registered, valid when push=1
//  pending      out  1    partial word held (idx != 0)
//  ovf          out  1    sticky: push issued while fifo_full=1
// BEHAVIOUR
//  - Reset (async, rst=1): push=0, push_data=0, idx=0, acc=all lanes PAD, ovf=0,
//    pending=0. in_rdy is combinational = !fifo_alFull (0 after reset only if alFull=1).
//  - Accept: acc = in_vld && in_rdy. No accept while in_rdy=0; idx/acc held.
//  - State = lane index idx, width $clog2(LANES): 0 = EMPTY, 1..LANES-1 = FILLING.
//    On accept, byte written to acc[idx*BW +: BW]; idx -> idx+1.
//  - Word complete when accept with idx==LANES-1 (or close, see CONFIGURATION):
//    next edge push=1, push_data = acc with current byte merged; idx -> 0, acc -> all PAD.
//    Latency: 1 cycle from completing accept to push. Back-to-back pushes allowed only
//    if LANES==1; otherwise at most one push per LANES accepts.
//  - push=0 in all other cycles; push_data holds last pushed word.
//  - ovf set on any edge where push is issued and fifo_full=1; cleared only by rst. The
//    packer does not retry; FIFO drops the word.
//  - idx wraps LANES-1 -> 0 only via a completed word; never exceeds LANES-1.
//  - fifo_alFull rising mid-word: partial word held indefinitely; resumes on deassert.
//  - Reset mid-word: partial bytes discarded, no push generated, pending=0 immediately.
// CONFIGURATION
//  PACKER_PAD_EN defined: accept with in_last=1 also completes the word; unwritten lanes
//   = PAD; push next cycle, idx -> 0. in_last on lane LANES-1: single push, no extra word.
//   in_last at idx 0: word = {PAD.., byte}.
//  PACKER_PAD_EN undefined: in_last ignored; words complete only when all LANES filled.
// TESTING (LANES=3, BW=8, PAD=0)
//  1 bytes 11,22,33 on 3 consecutive cycles, alFull=0 -> one push 1 cycle later,
//    push_data=24'h332211, pending 1,1,0.
//  2 six bytes 11..66 with random in_vld gaps -> exactly two pushes: 24'h332211,
//    24'h665544; no other push pulses.
//  3 PAD_EN: AA, BB(in_last=1) -> push 24'h00BBAA, pending=0. Without macro: no push,
//    pending=1; then CC -> push 24'hCCBBAA.
//  4 after one byte, alFull=1 for 10 cycles with in_vld=1 -> in_rdy=0, no accept, no push;
//    alFull=0 -> two more bytes complete word, correct lane order.
//  5 fifo_full=1 on the edge push issues -> ovf=1 and stays 1 until rst; further pushes unaffected.
//  6 rst pulse after bytes 11,22 -> push stays 0, pending=0; then 44,55,66 -> push 24'h665544.

Source files
------------

// File: rtl/fifo_byte_packer.sv
// -----------------------------------------------------------------------------
// fifo_byte_packer
//
// Purpose:
//   Upstream feeder for a synchronous FIFO. Accepts a byte stream with a
//   valid/ready handshake and packs LANES bytes little-endian into one
//   DW-bit word (lane 0 = first byte, in the low bits). Each completed word
//   is issued to the FIFO as a registered, single-cycle push.
//   Back-pressure comes from the FIFO almost-full flag. The FIFO keeps enough
//   headroom to absorb the push -> wen -> count -> alFull loop delay.
//
// Handshake:
//   A byte transfers on a rising edge where in_vld && in_rdy. in_rdy is purely
//   combinational (!fifo_alFull) and does not depend on in_vld. While in_rdy
//   is low, no byte is taken, and the lane index and accumulator hold.
//
// Optional feature (macro PACKER_PAD_EN):
//   When defined, an accepted byte with in_last=1 also completes the word.
//   Lanes that were not written carry PAD. When undefined, in_last is ignored.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   in_vld       in   1      input byte valid
//   in_data      in   BW     input byte
//   in_last      in   1      last byte of packet (PACKER_PAD_EN only)
//   in_rdy       out  1      packer accepts a byte this cycle
//   fifo_alFull  in   1      FIFO almost-full
//   fifo_full    in   1      FIFO full (overflow detection only)
//   push         out  1      FIFO push, registered 1-cycle pulse per word
//   push_data    out  DW     FIFO write data, valid when push=1
//   pending      out  1      a partial word is held (lane index != 0)
//   ovf          out  1      sticky: a push was issued while fifo_full=1
// -----------------------------------------------------------------------------
module fifo_byte_packer #(
    parameter int            BW    = 8,
    parameter int            LANES = 3,
    parameter logic [BW-1:0] PAD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic [BW-1:0]         in_data,
    input  logic                  in_last,
    output logic                  in_rdy,
    input  logic                  fifo_alFull,
    input  logic                  fifo_full,
    output logic                  push,
    output logic [BW*LANES-1:0]   push_data,
    output logic                  pending,
    output logic                  ovf
);

    localparam int DW = BW * LANES;
    // Keep the index at least one bit wide so that LANES=1 still elaborates.
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);
    localparam logic [DW-1:0] PAD_WORD = {LANES{PAD}};

    // The lane index is the packer state: 0 = EMPTY, 1..LANES-1 = FILLING.
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          push_q, push_d;
    logic [DW-1:0] push_data_q, push_data_d;
    logic          ovf_q, ovf_d;

    logic          accept;
    logic          last_hit;
    logic          word_done;
    logic [DW-1:0] merged;

`ifdef PACKER_PAD_EN
    assign last_hit = in_last;
`else
    // in_last has no effect in this build.
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign last_hit       = 1'b0;
`endif

    assign in_rdy    = !fifo_alFull;
    assign push      = push_q;
    assign push_data = push_data_q;
    assign pending   = (idx_q != '0);
    assign ovf       = ovf_q;

    always_comb begin
        accept = in_vld && in_rdy;

        // The accumulator with the incoming byte placed in the current lane.
        merged = acc_q;
        for (int i = 0; i < LANES; i++) begin
            if (idx_q == IW'(i)) begin
                merged[i*BW +: BW] = in_data;
            end
        end

        word_done = accept && ((idx_q == LAST_IDX) || last_hit);

        idx_d       = idx_q;
        acc_d       = acc_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;

        if (word_done) begin
            // Issue the finished word. Refill the accumulator with PAD
            // so that an early in_last sends PAD in the unwritten lanes.
            push_d      = 1'b1;
            push_data_d = merged;
            acc_d       = PAD_WORD;
            idx_d       = '0;
        end else if (accept) begin
            acc_d = merged;
            idx_d = idx_q + 1'b1;
        end

        // Overflow is flagged on the edge that issues a push into a full FIFO.
        ovf_d = ovf_q || (push_d && fifo_full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            acc_q       <= PAD_WORD;
            push_q      <= 1'b0;
            push_data_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fifo_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_byte_packer
//
// Directed bench for fifo_byte_packer with LANES=3, BW=8, PAD=0.
// A table of per-cycle records drives the inputs for one clock. The outputs
// are then sampled 1 time unit after the rising edge and compared with
// hand-computed values. After the table, a hand-written sequence sends six
// bytes with random idle gaps and checks the pushes against an expected queue.
// Build with +define+PACKER_PAD_EN to cover the in_last padding behaviour.
// -----------------------------------------------------------------------------
module tb_fifo_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_rdy;
    logic        fifo_alFull;
    logic        fifo_full;
    logic        push;
    logic [23:0] push_data;
    logic        pending;
    logic        ovf;

    int n_tests = 0;
    int n_fail  = 0;

    fifo_byte_packer #(.BW(8), .LANES(3), .PAD(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_rdy      (in_rdy),
        .fifo_alFull (fifo_alFull),
        .fifo_full   (fifo_full),
        .push        (push),
        .push_data   (push_data),
        .pending     (pending),
        .ovf         (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic        af;
        logic        full;
        logic        rst;
        logic        e_push;
        logic [23:0] e_data;
        logic        e_pend;
        logic        e_rdy;
        logic        e_ovf;
        logic        chk_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic vld, input logic [7:0] data,
                       input logic last, input logic af, input logic full, input logic r,
                       input logic e_push, input logic [23:0] e_data, input logic e_pend,
                       input logic e_rdy, input logic e_ovf, input logic chk_ovf);
        vec_t v;
        v.name = name; v.vld = vld; v.data = data; v.last = last; v.af = af;
        v.full = full; v.rst = r; v.e_push = e_push; v.e_data = e_data;
        v.e_pend = e_pend; v.e_rdy = e_rdy; v.e_ovf = e_ovf; v.chk_ovf = chk_ovf;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic vld, input logic [7:0] data, input logic last,
                         input logic af, input logic full, input logic r);
        in_vld = vld; in_data = data; in_last = last;
        fifo_alFull = af; fifo_full = full; rst = r;
    endtask

    // ---------------- scoreboard for random-gap sequence ----------------
    logic [23:0] exp_q[$];

    task automatic step_mon(input logic vld, input logic [7:0] data);
        drive(vld, data, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        if (push) begin
            if (exp_q.size() == 0) begin
                check("gap_extra_push", 32'(push_data), 32'hFFFF_FFFF);
            end else begin
                check("gap_push_data", 32'(push_data), 32'(exp_q.pop_front()));
            end
        end
    endtask

`ifdef PACKER_PAD_EN
    localparam logic [23:0] PD3 = 24'h000077;
`else
    localparam logic [23:0] PD3 = 24'hCCBBAA;
`endif

    initial begin
        logic [7:0] bytes [6];
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset state.
        add("reset",      0, 8'h00, 0, 0, 0, 1,  0, 24'h000000, 0, 1, 0, 1);
        // Three consecutive bytes -> one push one cycle later.
        add("t1_b0",      1, 8'h11, 0, 0, 0, 0,  0, 24'h000000, 1, 1, 0, 1);
        add("t1_b1",      1, 8'h22, 0, 0, 0, 0,  0, 24'h000000, 1, 1, 0, 1);
        add("t1_b2",      1, 8'h33, 0, 0, 0, 0,  1, 24'h332211, 0, 1, 0, 1);
        add("t1_idle",    0, 8'h00, 0, 0, 0, 0,  0, 24'h332211, 0, 1, 0, 1);
        // Almost-full stall mid-word.
        add("t4_b0",      1, 8'h44, 0, 0, 0, 0,  0, 24'h332211, 1, 1, 0, 1);
        for (int i = 0; i < 10; i++)
            add("t4_stall", 1, 8'h55, 0, 1, 0, 0, 0, 24'h332211, 1, 0, 0, 1);
        add("t4_b1",      1, 8'h55, 0, 0, 0, 0,  0, 24'h332211, 1, 1, 0, 1);
        add("t4_b2",      1, 8'h66, 0, 0, 0, 0,  1, 24'h665544, 0, 1, 0, 1);
        add("t4_idle",    0, 8'h00, 0, 0, 0, 0,  0, 24'h665544, 0, 1, 0, 1);
`ifdef PACKER_PAD_EN
        add("t3_b0",      1, 8'hAA, 0, 0, 0, 0,  0, 24'h665544, 1, 1, 0, 1);
        add("t3_last",    1, 8'hBB, 1, 0, 0, 0,  1, 24'h00BBAA, 0, 1, 0, 1);
        add("t3_idle",    0, 8'h00, 0, 0, 0, 0,  0, 24'h00BBAA, 0, 1, 0, 1);
        add("t3_last0",   1, 8'h77, 1, 0, 0, 0,  1, 24'h000077, 0, 1, 0, 1);
        add("t3_idle2",   0, 8'h00, 0, 0, 0, 0,  0, 24'h000077, 0, 1, 0, 1);
`else
        add("t3_b0",      1, 8'hAA, 0, 0, 0, 0,  0, 24'h665544, 1, 1, 0, 1);
        add("t3_last",    1, 8'hBB, 1, 0, 0, 0,  0, 24'h665544, 1, 1, 0, 1);
        add("t3_b2",      1, 8'hCC, 0, 0, 0, 0,  1, 24'hCCBBAA, 0, 1, 0, 1);
        add("t3_idle",    0, 8'h00, 0, 0, 0, 0,  0, 24'hCCBBAA, 0, 1, 0, 1);
`endif
        // Overflow: full held over the completing accept and the push cycle.
        add("t5_b0_full", 1, 8'h01, 0, 0, 1, 0,  0, PD3,        1, 1, 0, 1);
        add("t5_b1",      1, 8'h02, 0, 0, 0, 0,  0, PD3,        1, 1, 0, 1);
        add("t5_b2_full", 1, 8'h03, 0, 0, 1, 0,  1, 24'h030201, 0, 1, 0, 0);
        add("t5_ovf_set", 0, 8'h00, 0, 0, 1, 0,  0, 24'h030201, 0, 1, 1, 1);
        add("t5_ovf_hold",0, 8'h00, 0, 0, 0, 0,  0, 24'h030201, 0, 1, 1, 1);
        add("t5_b3",      1, 8'h04, 0, 0, 0, 0,  0, 24'h030201, 1, 1, 1, 1);
        add("t5_b4",      1, 8'h05, 0, 0, 0, 0,  0, 24'h030201, 1, 1, 1, 1);
        add("t5_b5",      1, 8'h06, 0, 0, 0, 0,  1, 24'h060504, 0, 1, 1, 1);
        // Reset mid-word discards the partial word and clears ovf.
        add("t6_b0",      1, 8'h11, 0, 0, 0, 0,  0, 24'h060504, 1, 1, 1, 1);
        add("t6_b1",      1, 8'h22, 0, 0, 0, 0,  0, 24'h060504, 1, 1, 1, 1);
        add("t6_rst",     0, 8'h00, 0, 0, 0, 1,  0, 24'h000000, 0, 1, 0, 1);
        add("t6_b2",      1, 8'h44, 0, 0, 0, 0,  0, 24'h000000, 1, 1, 0, 1);
        add("t6_b3",      1, 8'h55, 0, 0, 0, 0,  0, 24'h000000, 1, 1, 0, 1);
        add("t6_b4",      1, 8'h66, 0, 0, 0, 0,  1, 24'h665544, 0, 1, 0, 1);
        add("t6_idle",    0, 8'h00, 0, 0, 0, 0,  0, 24'h665544, 0, 1, 0, 1);

        #1;
        foreach (vecs[i]) begin
            drive(vecs[i].vld, vecs[i].data, vecs[i].last, vecs[i].af,
                  vecs[i].full, vecs[i].rst);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".push"},      32'(push),      32'(vecs[i].e_push));
            check({vecs[i].name, ".push_data"}, 32'(push_data), 32'(vecs[i].e_data));
            check({vecs[i].name, ".pending"},   32'(pending),   32'(vecs[i].e_pend));
            check({vecs[i].name, ".in_rdy"},    32'(in_rdy),    32'(vecs[i].e_rdy));
            if (vecs[i].chk_ovf)
                check({vecs[i].name, ".ovf"},   32'(ovf),       32'(vecs[i].e_ovf));
        end

        // Six bytes with random idle gaps -> exactly two pushes.
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q.push_back(24'h332211);
        exp_q.push_back(24'h665544);
        for (int i = 0; i < 6; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step_mon(1'b0, 8'h00);
            step_mon(1'b1, bytes[i]);
        end
        for (int g = 0; g < 4; g++) step_mon(1'b0, 8'h00);
        check("gap_missing_pushes", 32'(exp_q.size()), 32'd0);
        check("gap_pending", 32'(pending), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
